spram_arbiter: RTL
==================

Name: spram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one single-port synchronous RAM. Issues at most one access (write or read) per cycle.
- Uses round-robin with a bounded burst, so one requester cannot starve the other.
- Routes the 1-cycle read data back to the requester that issued the read.
- Sits between two client blocks (A, B) and a RAM with ports wr_en/rd_en/addr/data_in/data_out. Write has priority inside the RAM, but this block never asserts wr_en and rd_en together.

Parameters:
- DATA_WIDTH, 8, RAM word width
- DEPTH, 256, RAM words; address width AW = $clog2(DEPTH)
- BURST, 4, max consecutive grants to one requester while the other is waiting (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A access request; held until granted
- wr_a  in  1  A: 1=write, 0=read
- addr_a  in  AW  A address
- wdata_a  in  DATA_WIDTH  A write data
- gnt_a  out  1  A accepted this cycle (combinational)
- rvalid_a  out  1  A read data valid
- rdata_a  out  DATA_WIDTH  A read data
- req_b, wr_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as A, for requester B
- ram_wr_en  out  1  to RAM wr_en
- ram_rd_en  out  1  to RAM rd_en
- ram_addr  out  AW  to RAM addr
- ram_din  out  DATA_WIDTH  to RAM data_in
- ram_dout  in  DATA_WIDTH  from RAM data_out (valid the cycle after a read)

Behaviour:
- Handshake: a transfer occurs in cycle t when req_x=1 and gnt_x=1. The requester holds req/wr/addr/wdata stable until granted. It may change them, or drop req, in the cycle after the grant.
- State registers:
  - owner: 0=A, 1=B; reset 0.
  - cnt: $clog2(BURST+1) bits; reset 0.
  - rd_tag: which requester has a read in flight; reset: none.
- Grant decision (combinational, per cycle; "other" is the requester that is not the owner):
  - req[owner] && (cnt<BURST || !req[other]): grant owner. cnt <= min(cnt+1, BURST).
  - else if req[other]: grant other. owner <= other, cnt <= 1.
  - else: no grant. cnt <= 0, owner unchanged.
- Never more than one gnt high. gnt_a, gnt_b, ram_wr_en and ram_rd_en are forced 0 while rst_n=0.
- RAM drive (combinational from the granted requester):
  - ram_wr_en = gnt & wr; ram_rd_en = gnt & ~wr.
  - ram_addr and ram_din come from the granted requester.
  - With no grant: enables 0, addr/din = A's values (don't care).
- Read return latency is 1 cycle:
  - rvalid_x is registered: high in cycle t+1 if x was granted a read in cycle t; otherwise 0. Reset 0.
  - rdata_x = ram_dout (passthrough). It is meaningful only when rvalid_x=1.
  - Back-to-back reads are fully pipelined at 1 read per cycle.
- Write completes at the grant edge. A read of the same address in a later cycle returns the new data. A write granted in t followed by a read granted in t+1 is legal and returns the written value.
- BURST=1 gives strict alternation under contention. With only one requester active, it is granted every cycle and cnt saturates at BURST.
- Reset mid-operation clears rvalid, owner and cnt immediately. An in-flight read is discarded: no rvalid after reset release. The RAM contents are untouched.
- After reset release, the first grant goes to A if both request.

Decomposition:
- Shared package spram_pkg:
  - owner encoding constants OWN_A=1'b0, OWN_B=1'b1
  - localparam helper for AW
- One natural sub-module: spram_rr_pick. It is combinational and takes req_a, req_b, owner, cnt and BURST, and returns gnt_a, gnt_b and the next owner/cnt. It keeps the burst policy unit-testable.

Test Plan:
- Reset: rst_n=0 with req_a=req_b=1 -> gnt_a=gnt_b=0, ram enables 0, rvalid_a=rvalid_b=0. On release both requesting -> gnt_a first.
- Single requester: A writes 0x11 to addr 5, then reads addr 5 -> ram_wr_en in the write cycle; rvalid_a=1 with rdata_a=0x11 exactly 1 cycle after the read grant; gnt_a every cycle.
- Contention, BURST=4, both req held continuously -> grant pattern A,A,A,A,B,B,B,B,A… Never two gnt in one cycle.
- Burst saturation: A alone for 10 cycles, then B asserts req -> B granted the next cycle (cnt already at BURST). Then B holds for 4 grants while A waits.
- Interleaved reads: A reads addr 3 (=0xAA), B reads addr 7 (=0x55) in consecutive cycles -> rvalid_a then rvalid_b on consecutive cycles with 0xAA and 0x55; no cross-delivery.
- Reset during read: A read granted in cycle t, rst_n low in t+1 -> rvalid_a never asserts for that read. Post-reset owner=A, cnt=0.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM arbiter: owner encoding and
// width helpers used to size address and burst-counter fields.
package spram_pkg;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int burst);
        return $clog2(burst + 1);
    endfunction

endpackage

// File: rtl/spram_rr_pick.sv
// Combinational round-robin pick with a bounded burst: the owner keeps the
// grant until it has used BURST consecutive grants while the other waits.
module spram_rr_pick
    import spram_pkg::*;
#(
    parameter int BURST = 4,
    localparam int CW   = cnt_width(BURST)
) (
    input  logic          req_a,
    input  logic          req_b,
    input  logic          owner,
    input  logic [CW-1:0] cnt,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          owner_next,
    output logic [CW-1:0] cnt_next
);

    logic w_req_own;
    logic w_req_oth;

    assign w_req_own = (owner == OWN_B) ? req_b : req_a;
    assign w_req_oth = (owner == OWN_B) ? req_a : req_b;

    always_comb begin
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        owner_next = owner;
        cnt_next   = '0;
        if (w_req_own && ((cnt < CW'(BURST)) || !w_req_oth)) begin
            if (owner == OWN_B) gnt_b = 1'b1;
            else                gnt_a = 1'b1;
            // Saturate so a lone requester stays at BURST and yields at once.
            cnt_next = (cnt >= CW'(BURST)) ? CW'(BURST) : cnt + CW'(1);
        end else if (w_req_oth) begin
            if (owner == OWN_B) gnt_a = 1'b1;
            else                gnt_b = 1'b1;
            owner_next = ~owner;
            cnt_next   = CW'(1);
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM: one access
// per cycle, bounded-burst round robin, read data steered back with 1-cycle latency.
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int BURST      = 4,
    localparam int AW        = addr_width(DEPTH),
    localparam int CW        = cnt_width(BURST)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  wr_a,
    input  logic [AW-1:0]         addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  wr_b,
    input  logic [AW-1:0]         addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic          r_rvalid_a;
    logic          r_rvalid_b;

    logic          w_pick_a;
    logic          w_pick_b;
    logic          w_owner_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_gnt_a;
    logic          w_gnt_b;

    spram_rr_pick #(
        .BURST (BURST)
    ) u_pick (
        .req_a      (req_a),
        .req_b      (req_b),
        .owner      (r_owner),
        .cnt        (r_cnt),
        .gnt_a      (w_pick_a),
        .gnt_b      (w_pick_b),
        .owner_next (w_owner_next),
        .cnt_next   (w_cnt_next)
    );

    // Grants are gated by rst_n so nothing reaches the RAM while in reset.
    assign w_gnt_a = w_pick_a & rst_n;
    assign w_gnt_b = w_pick_b & rst_n;

    assign gnt_a     = w_gnt_a;
    assign gnt_b     = w_gnt_b;
    assign ram_wr_en = (w_gnt_a & wr_a) | (w_gnt_b & wr_b);
    assign ram_rd_en = (w_gnt_a & ~wr_a) | (w_gnt_b & ~wr_b);
    assign ram_addr  = w_gnt_b ? addr_b : addr_a;
    assign ram_din   = w_gnt_b ? wdata_b : wdata_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_A;
            r_cnt      <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_owner    <= w_owner_next;
            r_cnt      <= w_cnt_next;
            r_rvalid_a <= w_gnt_a & ~wr_a;
            r_rvalid_b <= w_gnt_b & ~wr_b;
        end
    end

    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a  = ram_dout;
    assign rdata_b  = ram_dout;

endmodule
